fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- IF stage of the 16-bit pipelined CPU: owns the PC, drives the instruction-memory address, and loads the IF/ID pipeline register.
- Consumes the control-flow requests resolved in ID: jump, call, ret, taken branch and taken FOR.
- Holds a hardware return-address stack (RAS) so nested CALL/RET work beyond the single architectural RR.

Parameters:
- ADDR_W, 16, PC / instruction-address width; word-addressed, PC advances by 1.
- INSTR_W, 16, instruction width.
- RAS_DEPTH, 4, number of return-stack entries; must be a power of 2, at least 2.
- RESET_PC, 0, PC value after reset.
- NOP_INSTR, 16'h0000, value loaded into if_instr for bubbles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard-unit freeze; hold PC, IF/ID and RAS.
- imem_addr  out  ADDR_W  instruction-memory address; equals the PC register.
- imem_rdata  in  INSTR_W  instruction at imem_addr; combinational, same-cycle.
- dec_jump  in  1  ID holds a JMP.
- dec_call  in  1  ID holds a CALL.
- dec_ret  in  1  ID holds a RET.
- dec_branch_taken  in  1  ID holds a BEQ/BNE that resolved taken.
- dec_for_taken  in  1  ID holds a FOR whose loop-back is taken.
- dec_target  in  ADDR_W  target for jump, call, branch and FOR.
- dec_link_pc  in  ADDR_W  return address of the CALL in ID (its PC+1).
- dec_rr_value  in  ADDR_W  architectural RR contents; fallback RET target.
- if_instr  out  INSTR_W  registered instruction to ID.
- if_pc  out  ADDR_W  registered PC of if_instr.
- if_pc_plus1  out  ADDR_W  registered if_pc+1, wraps modulo 2^ADDR_W.
- if_valid  out  1  if_instr is real; 0 means bubble.
- ras_count  out  clog2(RAS_DEPTH)+1  current number of RAS entries.
- ras_overflow  out  1  sticky: a CALL was pushed while the RAS was full.
- ras_underflow  out  1  sticky: a RET was taken while the RAS was empty.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - PC = RESET_PC; if_instr = NOP_INSTR; if_pc = 0; if_pc_plus1 = 0; if_valid = 0.
  - RAS empty: ras_count = 0, ras_overflow = 0, ras_underflow = 0.
  - Reset asserted mid-operation discards all in-flight state, including RAS contents.
- Redirect is asserted when any dec_* request is 1. Priority when several are set: ret > call > jump > for > branch.
- Per-edge action, first matching row wins:
  - stall=1: PC, IF/ID, RAS and flags all hold. Redirect inputs are ignored; ID re-presents them after the stall.
  - Redirect with stall=0:
    - PC <= redirect target.
    - if_valid <= 0, if_instr <= NOP_INSTR, if_pc and if_pc_plus1 hold (one-cycle bubble). The instruction fetched this cycle is discarded.
  - Otherwise (sequential fetch):
    - if_instr <= imem_rdata; if_pc <= PC; if_pc_plus1 <= PC+1; if_valid <= 1.
    - PC <= PC+1; 16'hFFFF wraps to 16'h0000.
- Redirect targets:
  - jump, call, for, branch: dec_target.
  - ret, RAS non-empty: top entry, which is popped (ras_count-1).
  - ret, RAS empty: dec_rr_value; ras_underflow <= 1.
- CALL pushes dec_link_pc.
  - RAS full: the oldest entry is overwritten (circular), ras_count stays at RAS_DEPTH, ras_overflow <= 1.
- RAS implementation: circular buffer with top pointer; push/pop only on non-stalled redirect edges. Push and pop never occur in the same cycle (priority rule).
- Latency:
  - Redirect at edge N: the target instruction appears in IF/ID at edge N+1. Total penalty: one bubble.
- Flags clear only on reset.

Test Plan:
- Reset release with RESET_PC=0 and imem[0..2]=16'h1111/2222/3333 -> if_valid 0 on the first cycle. Next three edges give if_instr 1111/2222/3333 with if_pc 0/1/2 and if_pc_plus1 1/2/3.
- PC=5, dec_jump=1, dec_target=16'h0040 -> next edge: if_valid=0, if_instr=NOP, PC=0x40. Following edge: if_pc=0x40, if_valid=1.
- Hold stall=1 for 3 cycles with dec_branch_taken=1 -> PC and if_* unchanged, no redirect. Release stall with branch still asserted -> redirect to dec_target.
- CALL link 0x10, CALL link 0x20, RET, RET -> ras_count 1,2,1,0; RET targets 0x20 then 0x10. A third RET targets dec_rr_value=0x99 and sets ras_underflow=1.
- 5 CALLs with links 1..5 at RAS_DEPTH=4 -> ras_overflow=1, ras_count=4. Four RETs target 5,4,3,2.
- PC=16'hFFFF sequential -> if_pc_plus1=0, PC=0. Assert rst_n low mid-RAS-use -> outputs go to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// IF stage: owns the PC, fetches into the IF/ID register and resolves ID redirects,
// including a circular return-address stack for nested CALL/RET.
module fetch_redirect_unit #(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        INSTR_W   = 16,
  parameter int unsigned        RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata,
  input  logic                       dec_jump,
  input  logic                       dec_call,
  input  logic                       dec_ret,
  input  logic                       dec_branch_taken,
  input  logic                       dec_for_taken,
  input  logic [ADDR_W-1:0]          dec_target,
  input  logic [ADDR_W-1:0]          dec_link_pc,
  input  logic [ADDR_W-1:0]          dec_rr_value,
  output logic [INSTR_W-1:0]         if_instr,
  output logic [ADDR_W-1:0]          if_pc,
  output logic [ADDR_W-1:0]          if_pc_plus1,
  output logic                       if_valid,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_top;

  logic              redirect_c;
  logic              ras_empty_c;
  logic              ras_full_c;
  logic              do_push_c;
  logic              do_pop_c;
  logic              do_unf_c;
  logic [PTR_W-1:0]  push_idx_c;
  logic [ADDR_W-1:0] target_c;
  logic [ADDR_W-1:0] pc_plus1_c;

  assign imem_addr = pc_q;

  // Redirect decode; RET outranks CALL so push and pop never coincide.
  always_comb begin
    redirect_c  = dec_ret | dec_call | dec_jump | dec_for_taken | dec_branch_taken;
    ras_empty_c = (ras_count == CNT_W'(0));
    ras_full_c  = (ras_count == CNT_W'(RAS_DEPTH));
    do_push_c   = !stall && !dec_ret && dec_call;
    do_pop_c    = !stall && dec_ret && !ras_empty_c;
    do_unf_c    = !stall && dec_ret && ras_empty_c;
    push_idx_c  = ras_top + PTR_W'(1);
    pc_plus1_c  = pc_q + ADDR_W'(1);
    target_c    = dec_target;
    if (dec_ret) begin
      target_c = ras_empty_c ? dec_rr_value : ras_mem[ras_top];
    end
  end

  // PC and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      if_instr    <= NOP_INSTR;
      if_pc       <= '0;
      if_pc_plus1 <= '0;
      if_valid    <= 1'b0;
    end else if (!stall) begin
      if (redirect_c) begin
        pc_q     <= target_c;
        if_instr <= NOP_INSTR;
        if_valid <= 1'b0;
      end else begin
        pc_q        <= pc_plus1_c;
        if_instr    <= imem_rdata;
        if_pc       <= pc_q;
        if_pc_plus1 <= pc_plus1_c;
        if_valid    <= 1'b1;
      end
    end
  end

  // Return-address stack; a push when full overwrites the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_mem[i] <= '0;
      ras_top       <= '1;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      if (do_push_c) begin
        ras_mem[push_idx_c] <= dec_link_pc;
        ras_top             <= push_idx_c;
        if (ras_full_c) ras_overflow <= 1'b1;
        else            ras_count    <= ras_count + CNT_W'(1);
      end
      if (do_pop_c) begin
        ras_top   <= ras_top - PTR_W'(1);
        ras_count <= ras_count - CNT_W'(1);
      end
      if (do_unf_c) ras_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: stimulus queues expected IF/ID + RAS state,
// a monitor pops and compares one entry after each rising edge.
module tb_fetch_redirect_unit;

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pcp1;
    logic [15:0] addr;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  localparam logic [4:0] R_NONE = 5'b00000;
  localparam logic [4:0] R_RET  = 5'b10000;
  localparam logic [4:0] R_CALL = 5'b01000;
  localparam logic [4:0] R_JMP  = 5'b00100;
  localparam logic [4:0] R_BR   = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        dec_jump = 1'b0, dec_call = 1'b0, dec_ret = 1'b0;
  logic        dec_branch_taken = 1'b0, dec_for_taken = 1'b0;
  logic [15:0] dec_target = '0, dec_link_pc = '0, dec_rr_value = '0;
  logic [15:0] if_instr, if_pc, if_pc_plus1;
  logic        if_valid;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  fetch_redirect_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dec_jump(dec_jump), .dec_call(dec_call), .dec_ret(dec_ret),
    .dec_branch_taken(dec_branch_taken), .dec_for_taken(dec_for_taken),
    .dec_target(dec_target), .dec_link_pc(dec_link_pc), .dec_rr_value(dec_rr_value),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1), .if_valid(if_valid),
    .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  // Instruction memory contents.
  function automatic logic [15:0] imem_f(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h1111;
      16'd1:   return 16'h2222;
      16'd2:   return 16'h3333;
      default: return a ^ 16'hC3C3;
    endcase
  endfunction

  always_comb imem_rdata = imem_f(imem_addr);

  function automatic exp_t mk(input logic v, input logic [15:0] ins, input logic [15:0] p,
                              input logic [15:0] p1, input logic [15:0] a, input logic [2:0] c,
                              input logic o, input logic u);
    exp_t e;
    e.valid = v; e.instr = ins; e.pc = p; e.pcp1 = p1; e.addr = a;
    e.cnt = c; e.ovf = o; e.unf = u;
    return e;
  endfunction

  function automatic exp_t actual();
    return mk(if_valid, if_instr, if_pc, if_pc_plus1, imem_addr, ras_count,
              ras_overflow, ras_underflow);
  endfunction

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b i=%h pc=%h p1=%h a=%h c=%0d o=%b u=%b, want v=%b i=%h pc=%h p1=%h a=%h c=%0d o=%b u=%b",
               name, act.valid, act.instr, act.pc, act.pcp1, act.addr, act.cnt, act.ovf, act.unf,
               exp.valid, exp.instr, exp.pc, exp.pcp1, exp.addr, exp.cnt, exp.ovf, exp.unf);
    end
  endtask

  // Drive one cycle's ID requests now and queue the state expected after the next edge.
  task automatic apply(input logic [4:0] req, input logic st, input logic [15:0] tgt,
                       input logic [15:0] link, input logic [15:0] rr, input exp_t e);
    {dec_ret, dec_call, dec_jump, dec_for_taken, dec_branch_taken} = req;
    stall = st; dec_target = tgt; dec_link_pc = link; dec_rr_value = rr;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [4:0] req, input logic st, input logic [15:0] tgt,
                      input logic [15:0] link, input logic [15:0] rr, input exp_t e);
    @(negedge clk);
    apply(req, st, tgt, link, rr, e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk); #2;
    end
    if (exp_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: the IF/ID register presents new contents after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare($sformatf("cycle@%0t", $time), actual(), exp_q.pop_front());
    end
  end

  initial begin
    exp_t rst_e;
    rst_e = mk(1'b0, 16'h0000, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    #3 compare("reset_hold", actual(), rst_e);
    @(negedge clk);
    rst_n = 1'b1;
    compare("reset_release", actual(), rst_e);

    // Sequential fetch from reset
    apply(R_NONE, 0, 0, 0, 0, mk(1, 16'h1111, 16'd0, 16'd1, 16'd1, 0, 0, 0));
    step(R_NONE, 0, 0, 0, 0, mk(1, 16'h2222, 16'd1, 16'd2, 16'd2, 0, 0, 0));
    step(R_NONE, 0, 0, 0, 0, mk(1, 16'h3333, 16'd2, 16'd3, 16'd3, 0, 0, 0));
    step(R_NONE, 0, 0, 0, 0, mk(1, imem_f(16'd3), 16'd3, 16'd4, 16'd4, 0, 0, 0));
    step(R_NONE, 0, 0, 0, 0, mk(1, imem_f(16'd4), 16'd4, 16'd5, 16'd5, 0, 0, 0));

    // Jump from PC=5: one bubble, then target fetched
    step(R_JMP, 0, 16'h0040, 0, 0, mk(0, 16'h0000, 16'd4, 16'd5, 16'h0040, 0, 0, 0));
    step(R_NONE, 0, 0, 0, 0, mk(1, imem_f(16'h0040), 16'h0040, 16'h0041, 16'h0041, 0, 0, 0));

    // Stall holds everything and ignores the taken branch
    for (int i = 0; i < 3; i++)
      step(R_BR, 1, 16'h0080, 0, 0, mk(1, imem_f(16'h0040), 16'h0040, 16'h0041, 16'h0041, 0, 0, 0));
    step(R_BR, 0, 16'h0080, 0, 0, mk(0, 16'h0000, 16'h0040, 16'h0041, 16'h0080, 0, 0, 0));
    step(R_NONE, 0, 0, 0, 0, mk(1, imem_f(16'h0080), 16'h0080, 16'h0081, 16'h0081, 0, 0, 0));

    // CALL/CALL/RET/RET then RET on empty RAS
    step(R_CALL, 0, 16'h0100, 16'h0010, 0, mk(0, 16'h0000, 16'h0080, 16'h0081, 16'h0100, 1, 0, 0));
    step(R_NONE, 0, 0, 0, 0, mk(1, imem_f(16'h0100), 16'h0100, 16'h0101, 16'h0101, 1, 0, 0));
    step(R_CALL, 0, 16'h0200, 16'h0020, 0, mk(0, 16'h0000, 16'h0100, 16'h0101, 16'h0200, 2, 0, 0));
    step(R_RET, 0, 16'h0BAD, 0, 16'h0099, mk(0, 16'h0000, 16'h0100, 16'h0101, 16'h0020, 1, 0, 0));
    step(R_NONE, 0, 0, 0, 0, mk(1, imem_f(16'h0020), 16'h0020, 16'h0021, 16'h0021, 1, 0, 0));
    step(R_RET, 0, 16'h0BAD, 0, 16'h0099, mk(0, 16'h0000, 16'h0020, 16'h0021, 16'h0010, 0, 0, 0));
    step(R_RET, 0, 16'h0BAD, 0, 16'h0099, mk(0, 16'h0000, 16'h0020, 16'h0021, 16'h0099, 0, 0, 1));
    step(R_NONE, 0, 0, 0, 0, mk(1, imem_f(16'h0099), 16'h0099, 16'h009A, 16'h009A, 0, 0, 1));

    // Five CALLs into a 4-deep RAS, then four RETs
    for (int i = 1; i <= 5; i++)
      step(R_CALL, 0, 16'h0300 + 16'(i), 16'(i), 0,
           mk(0, 16'h0000, 16'h0099, 16'h009A, 16'h0300 + 16'(i), (i > 4) ? 3'd4 : 3'(i), i == 5, 1));
    for (int i = 0; i < 4; i++)
      step(R_RET, 0, 16'h0BAD, 0, 16'h0077,
           mk(0, 16'h0000, 16'h0099, 16'h009A, 16'(5 - i), 3'(3 - i), 1, 1));
    step(R_NONE, 0, 0, 0, 0, mk(1, 16'h3333, 16'd2, 16'd3, 16'd3, 0, 1, 1));

    // PC wrap at 16'hFFFF
    step(R_JMP, 0, 16'hFFFF, 0, 0, mk(0, 16'h0000, 16'd2, 16'd3, 16'hFFFF, 0, 1, 1));
    step(R_NONE, 0, 0, 0, 0, mk(1, imem_f(16'hFFFF), 16'hFFFF, 16'h0000, 16'h0000, 0, 1, 1));
    step(R_NONE, 0, 0, 0, 0, mk(1, 16'h1111, 16'h0000, 16'h0001, 16'h0001, 0, 1, 1));
    step(R_CALL, 0, 16'h0500, 16'h0055, 0, mk(0, 16'h0000, 16'h0000, 16'h0001, 16'h0500, 1, 1, 1));
    drain();

    // Asynchronous reset between clock edges with a live RAS entry
    {dec_ret, dec_call, dec_jump, dec_for_taken, dec_branch_taken} = R_NONE;
    #1 rst_n = 1'b0;
    #1 compare("async_reset", actual(), rst_e);
    @(negedge clk);
    compare("async_reset_held", actual(), rst_e);
    rst_n = 1'b1;
    apply(R_RET, 0, 16'h0BAD, 0, 16'h0123, mk(0, 16'h0000, 16'h0, 16'h0, 16'h0123, 0, 0, 1));
    step(R_NONE, 0, 0, 0, 0, mk(1, imem_f(16'h0123), 16'h0123, 16'h0124, 16'h0124, 0, 0, 1));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule
